// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state encoding and reset constants for the core front end
package cpu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // addi x0,x0,0 keeps decode harmless until the first real fetch lands
    localparam logic [31:0] DEFAULT_NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/acknowledge bus
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit_pc_reg.sv
// pc_reg: architectural PC register with idle-only commit; FETCH_MISALIGN_CHECK_EN rejects misaligned npc instead of masking it
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic        busy_i,
    input  logic [31:0] npc_i,
    output logic [31:0] pc_o,
    output logic        reject_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        commit;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign reject_o = we_i && !busy_i && (npc_i[1:0] != 2'b00);
    assign pc_d     = npc_i;
`else
    assign reject_o = 1'b0;
    assign pc_d     = npc_i & 32'hFFFF_FFFC;
`endif

    // A commit while a fetch is in flight would move imem_addr under the memory, so it is dropped
    assign commit = we_i && !busy_i && !reject_o;

    // PC register: load on an accepted commit, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else if (commit)
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC holder and request/ack instruction fetcher; optional FETCH_MISALIGN_CHECK_EN rejects misaligned commits
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            npc,
    input  logic                   pc_we,
    input  logic                   fetch_req,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            pc,
    output logic [31:0]            ir,
    output logic                   ir_valid,
    output logic                   busy,
    output logic [31:0]            fetch_cnt,
    output logic                   misalign_err
);

    fetch_state_t state_q;
    logic         imem_req_q;
    logic [31:0]  ir_q;
    logic         ir_valid_q;
    logic [31:0]  fetch_cnt_q;
    logic         misalign_err_q;
    logic         reject;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (pc_we),
        .busy_i   (state_q == WAIT),
        .npc_i    (npc),
        .pc_o     (pc),
        .reject_o (reject)
    );

    // Fetch FSM: IDLE launches a request (using the just-committed pc), WAIT holds it until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            imem_req_q     <= 1'b0;
            ir_q           <= NOP_INSN;
            ir_valid_q     <= 1'b0;
            fetch_cnt_q    <= 32'd0;
            misalign_err_q <= 1'b0;
        end else begin
            ir_valid_q     <= 1'b0;
            misalign_err_q <= reject;
            if (state_q == IDLE) begin
                if (fetch_req && !reject) begin
                    state_q    <= WAIT;
                    imem_req_q <= 1'b1;
                end
            end else if (imem.imem_ack) begin
                state_q     <= IDLE;
                imem_req_q  <= 1'b0;
                ir_q        <= imem.imem_rdata;
                ir_valid_q  <= 1'b1;
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc;
    assign ir             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign busy           = (state_q == WAIT);
    assign fetch_cnt      = fetch_cnt_q;
    assign misalign_err   = misalign_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit (expectations follow FETCH_MISALIGN_CHECK_EN)
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        pc_we;
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic [31:0] fetch_cnt;
    logic        misalign_err;
    int          tests = 0;
    int          fails = 0;

    pc_fetch_unit_if imem ();

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .npc          (npc),
        .pc_we        (pc_we),
        .fetch_req    (fetch_req),
        .imem         (imem),
        .pc           (pc),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .busy         (busy),
        .fetch_cnt    (fetch_cnt),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; npc = 32'h0; pc_we = 1'b0; fetch_req = 1'b0;
        imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
        step(); step();
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        tests++; if (ir !== 32'h13) begin fails++; $display("FAIL reset_ir: got %h want %h", ir, 32'h13); end
        tests++; if ({ir_valid, imem.imem_req, busy, misalign_err} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {ir_valid, imem.imem_req, busy, misalign_err}); end
        tests++; if (fetch_cnt !== 32'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0", fetch_cnt); end
        tests++; if (imem.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem.imem_addr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_fetch();
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hAAAA_0001; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        tests++; if (imem.imem_req !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL basic_req: got req=%b busy=%b want 1 1", imem.imem_req, busy); end
        tests++; if (imem.imem_addr !== 32'h0) begin fails++; $display("FAIL basic_addr: got %h want 0", imem.imem_addr); end
        step();
        tests++; if (ir !== 32'hAAAA_0001 || ir_valid !== 1'b1) begin fails++; $display("FAIL basic_ir: got %h v=%b want aaaa0001 v=1", ir, ir_valid); end
        tests++; if (imem.imem_req !== 1'b0 || fetch_cnt !== 32'd1) begin fails++; $display("FAIL basic_done: got req=%b cnt=%0d want 0 1", imem.imem_req, fetch_cnt); end
        imem.imem_ack = 1'b0;
        step();
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse: got %b want 0", ir_valid); end
    endtask

    task automatic test_commit_and_fetch();
        npc = 32'h40; pc_we = 1'b1; fetch_req = 1'b1;
        step();
        pc_we = 1'b0; fetch_req = 1'b0;
        tests++; if (imem.imem_addr !== 32'h40 || pc !== 32'h40) begin fails++; $display("FAIL commit_addr: got addr=%h pc=%h want 40 40", imem.imem_addr, pc); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (busy !== 1'b1 || ir_valid !== 1'b0) begin fails++; $display("FAIL commit_busy%0d: got busy=%b v=%b want 1 0", i, busy, ir_valid); end
            step();
        end
        tests++; if (busy !== 1'b1 || imem.imem_addr !== 32'h40) begin fails++; $display("FAIL commit_busy3: got busy=%b addr=%h want 1 40", busy, imem.imem_addr); end
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBBBB_0002;
        step();
        imem.imem_ack = 1'b0;
        tests++; if (ir !== 32'hBBBB_0002 || ir_valid !== 1'b1 || busy !== 1'b0 || fetch_cnt !== 32'd2) begin fails++; $display("FAIL commit_done: got ir=%h v=%b busy=%b cnt=%0d want bbbb0002 1 0 2", ir, ir_valid, busy, fetch_cnt); end
    endtask

    task automatic test_pc_we_in_wait();
        fetch_req = 1'b1;
        step();
        npc = 32'h100; pc_we = 1'b1;
        step();
        pc_we = 1'b0; fetch_req = 1'b0;
        tests++; if (pc !== 32'h40 || imem.imem_addr !== 32'h40 || busy !== 1'b1) begin fails++; $display("FAIL wait_we: got pc=%h addr=%h busy=%b want 40 40 1", pc, imem.imem_addr, busy); end
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCCCC_0003;
        step();
        imem.imem_ack = 1'b0;
        tests++; if (ir !== 32'hCCCC_0003 || fetch_cnt !== 32'd3 || busy !== 1'b0) begin fails++; $display("FAIL wait_done: got ir=%h cnt=%0d busy=%b want cccc0003 3 0", ir, fetch_cnt, busy); end
        step();
        tests++; if (busy !== 1'b0 || pc !== 32'h40) begin fails++; $display("FAIL wait_noqueue: got busy=%b pc=%h want 0 40", busy, pc); end
    endtask

    task automatic test_back_to_back();
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDDDD_0004; fetch_req = 1'b1;
        step();
        step();
        tests++; if (ir_valid !== 1'b1 || busy !== 1'b0 || ir !== 32'hDDDD_0004) begin fails++; $display("FAIL b2b_first: got v=%b busy=%b ir=%h want 1 0 dddd0004", ir_valid, busy, ir); end
        imem.imem_rdata = 32'hEEEE_0005;
        step();
        fetch_req = 1'b0;
        tests++; if (busy !== 1'b1 || imem.imem_req !== 1'b1 || ir_valid !== 1'b0) begin fails++; $display("FAIL b2b_relaunch: got busy=%b req=%b v=%b want 1 1 0", busy, imem.imem_req, ir_valid); end
        step();
        imem.imem_ack = 1'b0;
        tests++; if (ir !== 32'hEEEE_0005 || ir_valid !== 1'b1 || fetch_cnt !== 32'd5) begin fails++; $display("FAIL b2b_second: got ir=%h v=%b cnt=%0d want eeee0005 1 5", ir, ir_valid, fetch_cnt); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_err;
        logic        exp_busy;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_pc = 32'h40; exp_err = 1'b1; exp_busy = 1'b0;
`else
        exp_pc = 32'h40; exp_err = 1'b0; exp_busy = 1'b1;
`endif
        npc = 32'h42; pc_we = 1'b1; fetch_req = 1'b1;
        step();
        pc_we = 1'b0; fetch_req = 1'b0;
        tests++; if (pc !== exp_pc || misalign_err !== exp_err || busy !== exp_busy) begin fails++; $display("FAIL mis_42: got pc=%h err=%b busy=%b want %h %b %b", pc, misalign_err, busy, exp_pc, exp_err, exp_busy); end
        imem.imem_ack = busy; imem.imem_rdata = 32'h1111_0006;
        step();
        imem.imem_ack = 1'b0;
        tests++; if (misalign_err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mis_pulse: got err=%b busy=%b want 0 0", misalign_err, busy); end
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_pc = 32'h40;
`else
        exp_pc = 32'h84;
`endif
        npc = 32'h87; pc_we = 1'b1;
        step();
        pc_we = 1'b0;
        tests++; if (pc !== exp_pc || misalign_err !== exp_err) begin fails++; $display("FAIL mis_87: got pc=%h err=%b want %h %b", pc, misalign_err, exp_pc, exp_err); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmw_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (pc !== 32'h0 || imem.imem_req !== 1'b0 || ir !== 32'h13 || busy !== 1'b0 || fetch_cnt !== 32'h0) begin fails++; $display("FAIL rmw_async: got pc=%h req=%b ir=%h busy=%b cnt=%0d want 0 0 13 0 0", pc, imem.imem_req, ir, busy, fetch_cnt); end
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2222_0007;
        #2;
        rst_n = 1'b1;
        step();
        tests++; if (ir_valid !== 1'b0 || ir !== 32'h13 || busy !== 1'b0) begin fails++; $display("FAIL rmw_ack1: got v=%b ir=%h busy=%b want 0 13 0", ir_valid, ir, busy); end
        step();
        tests++; if (ir_valid !== 1'b0 || fetch_cnt !== 32'h0) begin fails++; $display("FAIL rmw_ack2: got v=%b cnt=%0d want 0 0", ir_valid, fetch_cnt); end
        imem.imem_ack = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        tests++; if (fetch_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_preset: got %h want ffffffff", fetch_cnt); end
        fetch_req = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 32'h3333_0008;
        step();
        fetch_req = 1'b0;
        step();
        imem.imem_ack = 1'b0;
        tests++; if (fetch_cnt !== 32'h0 || ir_valid !== 1'b1 || ir !== 32'h3333_0008) begin fails++; $display("FAIL wrap_cnt: got cnt=%h v=%b ir=%h want 0 1 33330008", fetch_cnt, ir_valid, ir); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_commit_and_fetch();
        test_pc_we_in_wait();
        test_back_to_back();
        test_misalign();
        test_reset_mid_wait();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Holds the architectural program counter and fetches instructions for the multi-cycle core. Sits directly downstream of the next-PC mux: it commits the computed next PC when the control FSM asks for it. It runs a request/acknowledge fetch from instruction memory at the current PC and latches the returned word into the instruction register for decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- npc  in  32  next PC from the next-PC mux, combinational.
- pc_we  in  1  commit npc into pc this cycle (control FSM, one-cycle pulse).
- fetch_req  in  1  start an instruction fetch at the (post-commit) pc.
- imem_req  out  1  memory request, registered, held until acknowledged.
- imem_addr  out  32  fetch address, equals pc.
- imem_ack  in  1  memory acknowledge, sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- pc  out  32  current program counter.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse: ir was updated on this edge.
- busy  out  1  fetch in flight (state WAIT).
- fetch_cnt  out  32  count of completed fetches, wraps modulo 2^32.
- misalign_err  out  1  one-cycle pulse, rejected misaligned npc (see Configuration).

## Operation
- FSM states: IDLE, WAIT. Encoding is a package enum.
- IDLE:
  - fetch_req=1 goes to WAIT and sets imem_req=1 on the next edge.
  - Otherwise the FSM stays in IDLE.
- WAIT:
  - imem_req=1. imem_addr=pc, stable throughout.
  - imem_ack=1 latches ir<=imem_rdata, pulses ir_valid, increments fetch_cnt, clears imem_req, and returns to IDLE.
- pc_we:
  - In IDLE, pc<=npc on the edge.
  - In WAIT, pc_we is ignored and pc is unchanged. Using pc_we while busy is a control protocol violation, and the bench checks that it has no effect.
- pc_we and fetch_req in the same IDLE cycle: the commit happens first, and the fetch uses the new pc. The next cycle shows imem_addr=npc.
- fetch_req while in WAIT is ignored. It is not queued.
- fetch_req is accepted in the cycle ir_valid is high, because the FSM is already in IDLE.
- Arithmetic:
  - pc is exactly 32 bits.
  - No increment happens here; the next-PC mux supplies pc+4.
  - fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- Reset (asynchronous, any state, including mid-fetch):
  - Outputs: pc=RESET_PC, ir=NOP_INSN, ir_valid=0, imem_req=0, busy=0, fetch_cnt=0, misalign_err=0. imem_addr=RESET_PC.
  - State returns to IDLE. An outstanding ack after reset release is ignored because imem_req=0.

## Timing
- Fetch latency: fetch_req sampled at edge N gives imem_req=1 from N+1. An ack sampled at edge M≥N+1 gives ir/ir_valid at M+1, with imem_req=0 at M+1.
- Zero-wait memory (ack in the first request cycle): 2 cycles per fetch, and back-to-back fetches are possible.
- pc update is visible one edge after pc_we.
- All outputs are registered except imem_addr, which is a wire from pc.

## Configuration
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - pc_we with npc[1:0]!=0 leaves pc unchanged and pulses misalign_err on the next edge.
  - Any fetch_req in that same cycle is dropped, and the FSM stays in IDLE.
- Undefined:
  - pc loads {npc[31:2],2'b00}.
  - misalign_err is tied 0.

## Structure
- Shared package cpu_pkg holds:
  - fetch_state_t enum {IDLE, WAIT}.
  - NOP_INSN constant.
  - RESET_PC default constant.
- One sub-module, pc_reg: the pc register with write enable, busy gating and the alignment check/masking under FETCH_MISALIGN_CHECK_EN. It outputs pc and a reject flag.
- The FSM, ir and fetch_cnt live in pc_fetch_unit.

## Test plan
- Reset release, fetch_req pulse, ack held 1 → imem_addr=0, ir=imem_rdata at cycle 3, ir_valid pulse, fetch_cnt=1.
- pc_we with npc=32'h0000_0040 and fetch_req in the same cycle → next cycle imem_addr=32'h40. Ack after 3 wait cycles → ir latched, busy high for 4 cycles.
- pc_we=1 with npc=32'h100 while in WAIT → pc unchanged. Ack completes normally.
- npc=32'h0000_0042, pc_we=1 → with macro: pc unchanged and misalign_err pulse. Without macro: pc=32'h40 and misalign_err=0.
- rst_n asserted mid-WAIT → immediate pc=RESET_PC, imem_req=0, ir=32'h13. A later ack produces no ir_valid.
- Force fetch_cnt to 32'hFFFF_FFFF, then complete one fetch → fetch_cnt=0.
